// File: rtl/sound_mixer.sv
// Time-multiplexed mixer. Each output sample is the sum of the per-channel
// products (sample times gain), computed with one multiply-add per clock.
module sound_mixer #(
    parameter int NUM_CH = 4,
    parameter int SHIFT  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en_48KHz,
    input  logic                  master_en,
    input  logic [16*NUM_CH-1:0]  ch_in,
    input  logic [4*NUM_CH-1:0]   ch_gain,
    output logic [15:0]           out,
    output logic                  out_valid,
    output logic                  overrun
);

    localparam int ACC_W = 20 + $clog2(NUM_CH);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [IDX_W-1:0]   idx_q;
    logic [15:0]        snap_in_q   [NUM_CH];
    logic [3:0]         snap_gain_q [NUM_CH];
    logic               snap_en_q;
    logic [15:0]        out_q;
    logic               valid_q;
    logic               overrun_q;
    logic [15:0]        cur_in_s;
    logic [3:0]         cur_gain_s;
    logic [19:0]        prod_s;

    // Shift the accumulator down and clamp anything above 16 bits to full scale.
    function automatic logic [15:0] sat16(input logic [ACC_W-1:0] v);
        logic [ACC_W-1:0] sh;
        sh = v >> SHIFT;
        if (|sh[ACC_W-1:16]) begin
            return 16'hFFFF;
        end else begin
            return sh[15:0];
        end
    endfunction

    // Select the snapshot channel addressed by idx and form its product.
    always_comb begin
        cur_in_s   = 16'd0;
        cur_gain_s = 4'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (IDX_W'(k) == idx_q) begin
                cur_in_s   = snap_in_q[k];
                cur_gain_s = snap_gain_q[k];
            end else begin
                cur_in_s   = cur_in_s;
                cur_gain_s = cur_gain_s;
            end
        end
        prod_s = {4'd0, cur_in_s} * {16'd0, cur_gain_s};
        acc_d  = acc_q + {{(ACC_W-20){1'b0}}, prod_s};
    end

    // Sequencer: snapshot on strobe, accumulate one channel per clock, emit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            idx_q     <= '0;
            snap_en_q <= 1'b0;
            out_q     <= 16'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                snap_in_q[k]   <= 16'd0;
                snap_gain_q[k] <= 4'd0;
            end
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clk_en_48KHz) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            snap_in_q[k]   <= ch_in[16*k +: 16];
                            snap_gain_q[k] <= ch_gain[4*k +: 4];
                        end
                        snap_en_q <= master_en;
                        acc_q     <= '0;
                        idx_q     <= '0;
                        state_q   <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    if (idx_q == LAST_IDX) begin
                        state_q <= EMIT;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                EMIT: begin
                    out_q   <= snap_en_q ? sat16(acc_q) : 16'd0;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // A strobe that cannot be accepted is dropped but remembered.
            if (clk_en_48KHz && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sound_mixer.sv
// Randomized self-checking bench for sound_mixer against an arithmetic mix model.
module tb_sound_mixer;

    localparam int NCH = 4;

    logic              clk;
    logic              rst_n;
    logic              strb;
    logic              men;
    logic [16*NCH-1:0] ch_in;
    logic [4*NCH-1:0]  ch_gain;
    logic [15:0]       out_s;
    logic              out_valid_s;
    logic              overrun_s;

    int ch_m [NCH];
    int g_m  [NCH];
    bit en_m;
    int checks;
    int errors;

    sound_mixer #(.NUM_CH(NCH), .SHIFT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_en_48KHz (strb),
        .master_en    (men),
        .ch_in        (ch_in),
        .ch_gain      (ch_gain),
        .out          (out_s),
        .out_valid    (out_valid_s),
        .overrun      (overrun_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_out();
        longint sum;
        sum = 0;
        for (int k = 0; k < NCH; k++) sum += longint'(ch_m[k]) * longint'(g_m[k]);
        sum = sum / 16;
        if (sum > 65535) sum = 65535;
        return en_m ? int'(sum) : 0;
    endfunction

    task automatic apply_inputs();
        for (int k = 0; k < NCH; k++) begin
            ch_in[16*k +: 16] = ch_m[k][15:0];
            ch_gain[4*k +: 4] = g_m[k][3:0];
        end
        men = en_m;
    endtask

    task automatic randomize_model();
        for (int k = 0; k < NCH; k++) begin
            case ($urandom_range(0, 3))
                0: ch_m[k] = 65535;
                1: ch_m[k] = 0;
                default: ch_m[k] = int'($urandom_range(0, 65535));
            endcase
            g_m[k] = int'($urandom_range(0, 15));
        end
        en_m = ($urandom_range(0, 4) != 0);
    endtask

    task automatic set_model(input int c0, input int g0, input int c1, input int g1,
                             input int c2, input int g2, input int c3, input int g3);
        ch_m[0] = c0; g_m[0] = g0; ch_m[1] = c1; g_m[1] = g1;
        ch_m[2] = c2; g_m[2] = g2; ch_m[3] = c3; g_m[3] = g3;
        en_m = 1'b1;
    endtask

    // Strobe for one cycle; returns at cycle index 1 (one clock after the strobe cycle).
    task automatic strobe_once();
        @(posedge clk); #1;
        strb = 1'b1;
        @(posedge clk); #1;
        strb = 1'b0;
    endtask

    task automatic check_cycle(input string name, input int c, input int exp);
        checks++;
        if (out_valid_s !== (c == 6)) begin
            errors++;
            $display("FAIL %s out_valid at T+%0d: got %b expected %b", name, c, out_valid_s, (c == 6));
        end
        if (c == 6) begin
            checks++;
            if (out_s !== exp[15:0]) begin
                errors++;
                $display("FAIL %s out: got %h expected %h", name, out_s, exp[15:0]);
            end
        end
    endtask

    task automatic do_sample(input string name);
        int exp;
        exp = model_out();
        apply_inputs();
        strobe_once();
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            check_cycle(name, c, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; strb = 1'b0; men = 1'b0; ch_in = '0; ch_gain = '0;
        #12;
        checks++;
        if (out_s !== 16'd0 || out_valid_s !== 1'b0 || overrun_s !== 1'b0) begin
            errors++;
            $display("FAIL reset: got out=%h valid=%b overrun=%b expected 0/0/0", out_s, out_valid_s, overrun_s);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        set_model(32'h8000, 15, 0, 0, 0, 0, 0, 0);
        do_sample("single");
    endtask

    task automatic test_saturation();
        set_model(65535, 15, 65535, 15, 65535, 15, 65535, 15);
        do_sample("saturation");
    endtask

    task automatic test_mix();
        set_model(1000, 8, 2000, 4, 400, 15, 0, 0);
        do_sample("mix");
    endtask

    task automatic test_snapshot();
        int exp;
        set_model(32'h1000, 15, 0, 0, 0, 0, 0, 0);
        exp = model_out();
        apply_inputs();
        strobe_once();
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == 2) begin
                ch_in[15:0] = 16'hFFFF; ch_gain = '1; men = 1'b0;
            end
            check_cycle("snapshot", c, exp);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            randomize_model();
            do_sample("random");
        end
    endtask

    task automatic test_back_to_back();
        int exp;
        randomize_model(); en_m = 1'b1;
        apply_inputs();
        exp = model_out();
        @(posedge clk); #1;
        strb = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(posedge clk); #1;
            strb = 1'b0;
            for (int c = 2; c <= 6; c++) begin
                @(posedge clk); #1;
                check_cycle("back_to_back", c, exp);
                if (c == 6 && s < 3) begin
                    randomize_model();
                    apply_inputs();
                    exp = model_out();
                    strb = 1'b1;
                end
            end
        end
        checks++;
        if (overrun_s !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back overrun: got %b expected 0", overrun_s);
        end
    endtask

    task automatic test_emit_edge();
        int exp;
        randomize_model(); en_m = 1'b1;
        exp = model_out();
        apply_inputs();
        strobe_once();
        for (int c = 1; c <= 13; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            strb = (c == 5);
            check_cycle("emit_edge", c, exp);
        end
        checks++;
        if (overrun_s !== 1'b1) begin
            errors++;
            $display("FAIL emit_edge overrun: got %b expected 1", overrun_s);
        end
    endtask

    task automatic test_overrun_mute();
        int exp;
        rst_n = 1'b0; #3; rst_n = 1'b1;
        set_model(3000, 7, 500, 9, 12345, 2, 777, 15);
        exp = model_out();
        apply_inputs();
        strobe_once();
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            strb = (c == 2);
            check_cycle("overrun", c, exp);
        end
        checks++;
        if (overrun_s !== 1'b1) begin
            errors++;
            $display("FAIL overrun sticky: got %b expected 1", overrun_s);
        end
        randomize_model(); en_m = 1'b0;
        do_sample("mute");
        checks++;
        if (overrun_s !== 1'b1) begin
            errors++;
            $display("FAIL overrun hold: got %b expected 1", overrun_s);
        end
    endtask

    task automatic test_reset_mid();
        set_model(32'h4000, 15, 32'h2000, 8, 0, 0, 0, 0);
        do_sample("pre_reset");
        set_model(32'hFFFF, 15, 32'hFFFF, 15, 0, 0, 0, 0);
        apply_inputs();
        strobe_once();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_s !== 16'd0 || out_valid_s !== 1'b0 || overrun_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got out=%h valid=%b overrun=%b expected 0/0/0", out_s, out_valid_s, overrun_s);
        end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid_s !== 1'b0 || out_s !== 16'd0) begin
                errors++;
                $display("FAIL reset_mid_after: got valid=%b out=%h expected 0/0000", out_valid_s, out_s);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_saturation();
        test_mix();
        test_snapshot();
        test_random();
        test_back_to_back();
        test_emit_edge();
        test_overrun_mute();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
